id_ex_operand_reg: RTL

ID_EX_OPERAND_REG -- requirements
Module: id_ex_operand_reg

---
 rtl/id_ex_operand_reg_pkg.sv | 50 +++++
 rtl/id_ex_operand_reg_dff.sv | 26 ++
 rtl/id_ex_operand_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/id_ex_operand_reg_pkg.sv
// Shared ALU encodings and the ID/EX operand bundle layout.
// The op-code enum fixes the op field width; the EX stage decodes it.
package id_ex_operand_reg_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

   localparam int ALU_OP_W = $bits(alu_op_e);

   // a + b + op + inva + invb + cin = 38 bits
   localparam int BUNDLE_W = 2 * DATA_W + ALU_OP_W + 3;

   typedef struct packed {
      logic [DATA_W-1:0]   a;
      logic [DATA_W-1:0]   b;
      logic [ALU_OP_W-1:0] op;
      logic                inva;
      logic                invb;
      logic                cin;
   } bundle_t;

   function automatic bundle_t pack_bundle(
      input logic [DATA_W-1:0]   a,
      input logic [DATA_W-1:0]   b,
      input logic [ALU_OP_W-1:0] op,
      input logic                inva,
      input logic                invb,
      input logic                cin
   );
      bundle_t bnd;
      bnd.a    = a;
      bnd.b    = b;
      bnd.op   = op;
      bnd.inva = inva;
      bnd.invb = invb;
      bnd.cin  = cin;
      return bnd;
   endfunction

endpackage

// File: rtl/id_ex_operand_reg_dff.sv
// Single-bit storage cell with synchronous active-high reset to 0.
module id_ex_operand_reg_dff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic state_d;
   logic state_q;

   always_comb begin
      state_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= 1'b0;
      end else begin
         state_q <= state_d;
      end
   end

   assign q = state_q;

endmodule

// File: rtl/id_ex_operand_reg.sv
// ID/EX operand register: two-entry skid buffer (main + skid slot) between
// decode and execute; in_ready comes straight from the skid valid flop.
module id_ex_operand_reg
   import id_ex_operand_reg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_a,
   input  logic [DATA_W-1:0]   in_b,
   input  logic [ALU_OP_W-1:0] in_op,
   input  logic                in_inva,
   input  logic                in_invb,
   input  logic                in_cin,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_a,
   output logic [DATA_W-1:0]   out_b,
   output logic [ALU_OP_W-1:0] out_op,
   output logic                out_inva,
   output logic                out_invb,
   output logic                out_cin,
   output logic [1:0]          occ
);

   bundle_t             in_bundle;
   bundle_t             main_d;
   bundle_t             skid_d;
   bundle_t             main_q;
   bundle_t             skid_q;
   logic [BUNDLE_W-1:0] main_q_flat;
   logic [BUNDLE_W-1:0] skid_q_flat;
   logic                main_vld_d;
   logic                main_vld_q;
   logic                skid_vld_d;
   logic                skid_vld_q;
   logic                accept;
   logic                drain;

   assign in_bundle = pack_bundle(in_a, in_b, in_op, in_inva, in_invb, in_cin);
   assign accept    = in_valid & ~skid_vld_q;
   assign drain     = main_vld_q & out_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (drain) begin
         // An accept implies the skid slot is empty, so it can never race the skid-to-main move.
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = in_bundle;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_vld_q) begin
            main_d     = in_bundle;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = in_bundle;
            skid_vld_d = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BUNDLE_W; gi++) begin : g_slot_bits
         id_ex_operand_reg_dff u_main_bit (
            .clk (clk),
            .rst (rst),
            .d   (main_d[gi]),
            .q   (main_q_flat[gi])
         );
         id_ex_operand_reg_dff u_skid_bit (
            .clk (clk),
            .rst (rst),
            .d   (skid_d[gi]),
            .q   (skid_q_flat[gi])
         );
      end
   endgenerate

   id_ex_operand_reg_dff u_main_vld (
      .clk (clk),
      .rst (rst),
      .d   (main_vld_d),
      .q   (main_vld_q)
   );

   id_ex_operand_reg_dff u_skid_vld (
      .clk (clk),
      .rst (rst),
      .d   (skid_vld_d),
      .q   (skid_vld_q)
   );

   assign main_q = bundle_t'(main_q_flat);
   assign skid_q = bundle_t'(skid_q_flat);

   assign in_ready  = ~skid_vld_q;
   assign out_valid = main_vld_q;
   assign out_a     = main_q.a;
   assign out_b     = main_q.b;
   assign out_op    = main_q.op;
   assign out_inva  = main_q.inva;
   assign out_invb  = main_q.invb;
   assign out_cin   = main_q.cin;
   assign occ       = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule
